// File: rtl/uart_tx_arb.sv
// Round-robin arbiter in front of the UART TX FIFO write port: one requester owns
// the FIFO for a whole message (ending on last); a watchdog and a soft clear can end ownership early.
module uart_tx_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int START_FREE = 4,
   parameter int STALL_MAX  = 64,
   localparam int IDX_W     = $clog2(NUM_REQ),
   localparam int LVL_W     = $clog2(DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic                          fifo_clear,
   input  logic                          fifo_full,
   input  logic [LVL_W-1:0]              fifo_level,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          stall_err,
   output logic                          dbg_state,
   output logic [IDX_W-1:0]              dbg_rr_ptr
);

   // Handshake: a byte moves from requester i into the FIFO in any cycle where
   // req_valid[i] & req_ready[i]; fifo_wr_en is exactly that condition for the owner.

   localparam int WD_W = $clog2(STALL_MAX + 1);
   localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] START_L   = LVL_W'(START_FREE);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(STALL_MAX - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t           state, state_d;
   logic [IDX_W-1:0] owner, owner_d;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
   logic [WD_W-1:0]  wd_cnt, wd_cnt_d;
   logic             stall_q, stall_d;
   logic [LVL_W-1:0] free;
   logic [IDX_W:0]   pick;
   logic [IDX_W-1:0] next_ptr;
   logic             xfer;

   // Lowest rotation offset from ptr wins; bit IDX_W flags that someone requested.
   function automatic logic [IDX_W:0] pick_next(input logic [NUM_REQ-1:0] v,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W:0] res;
      int             idx;
      res = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (v[idx]) res = {1'b1, IDX_W'(idx)};
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner   <= '0;
         rr_ptr  <= '0;
         wd_cnt  <= '0;
         stall_q <= 1'b0;
      end else begin
         state   <= state_d;
         owner   <= owner_d;
         rr_ptr  <= rr_ptr_d;
         wd_cnt  <= wd_cnt_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      free         = DEPTH_L - fifo_level;
      pick         = pick_next(req_valid, rr_ptr);
      next_ptr     = (owner == IDX_LAST) ? '0 : owner + 1'b1;
      busy         = (state == BUSY);
      fifo_clear   = clear;
      req_ready    = '0;
      grant        = '0;
      fifo_wr_data = '0;
      // Ready is withheld during clear so no requester sees a byte accepted that is never written.
      if (busy) begin
         grant[owner]     = 1'b1;
         req_ready[owner] = !fifo_full && !clear;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (busy && owner == IDX_W'(i)) fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      xfer       = busy && req_valid[owner] && !fifo_full && !clear;
      fifo_wr_en = xfer;

      state_d  = state;
      owner_d  = owner;
      rr_ptr_d = rr_ptr;
      wd_cnt_d = wd_cnt;
      stall_d  = 1'b0;
      if (clear) begin
         state_d  = IDLE;
         wd_cnt_d = '0;
      end else begin
         case (state)
            IDLE: begin
               wd_cnt_d = '0;
               if (pick[IDX_W] && free >= START_L) begin
                  state_d = BUSY;
                  owner_d = pick[IDX_W-1:0];
               end
            end
            BUSY: begin
               if (xfer) begin
                  wd_cnt_d = '0;
                  if (req_last[owner]) begin
                     state_d  = IDLE;
                     rr_ptr_d = next_ptr;
                  end
               end else if (wd_cnt == WD_LAST) begin
                  stall_d  = 1'b1;
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
                  wd_cnt_d = '0;
               end else begin
                  wd_cnt_d = wd_cnt + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign stall_err  = stall_q;
   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: expected FIFO bytes are queued by the stimulus
// and popped by a negedge monitor; arbitration timing is checked inline.
module tb_uart_tx_arb;

   localparam int NR = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clear = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]   req_last = '0;
   logic [NR-1:0]   req_ready;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wr_data;
   logic            fifo_clear;
   logic            fifo_full = 1'b0;
   logic [4:0]      fifo_level = '0;
   logic [NR-1:0]   grant;
   logic            busy;
   logic            stall_err;
   logic            dbg_state;
   logic [1:0]      dbg_rr_ptr;

   uart_tx_arb dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .fifo_clear(fifo_clear), .fifo_full(fifo_full), .fifo_level(fifo_level),
      .grant(grant), .busy(busy), .stall_err(stall_err),
      .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] exp_q[$];
   int            wr_cyc[$];
   int            n_pass = 0;
   int            n_total = 0;
   int            stall_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && fifo_wr_en) begin
         if (exp_q.size() == 0) check("unexpected_write", 32'(fifo_wr_data), 32'hffff_ffff);
         else check("fifo_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
         wr_cyc.push_back(cyc);
      end
      if (rst_n && stall_err) stall_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input logic [DW-1:0] d, input logic l);
      req_valid[r]         = 1'b1;
      req_data[r*DW +: DW] = d;
      req_last[r]          = l;
   endtask

   task automatic release_req(input int r);
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   task automatic send_msg(input int r, input logic [DW-1:0] b0, input logic [DW-1:0] b1);
      logic acc;
      int   tmo;
      for (int i = 0; i < 2; i++) begin
         drive(r, (i == 0) ? b0 : b1, i == 1);
         tmo = 0;
         do begin
            @(negedge clk);
            acc = req_ready[r];
            tmo++;
            tick();
         end while (!acc && tmo < 100);
         if (!acc) check("send_timeout", 32'(tmo), 32'd0);
      end
      release_req(r);
   endtask

   initial begin
      int stall_seen;
      int own_cycles;
      // Reset
      repeat (3) tick();
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_wr_data", 32'(fifo_wr_data), 32'd0);
      check("rst_clear", 32'(fifo_clear), 32'd0);
      check("rst_stall", 32'(stall_err), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_rr", 32'(dbg_rr_ptr), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: requester 1 sends 41 42 43
      wr_cyc.delete();
      exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
      drive(1, 8'h41, 1'b0);
      @(negedge clk);
      check("t1_no_grant_yet", 32'(grant), 32'd0);
      tick();
      @(negedge clk);
      check("t1_grant", 32'(grant), 32'b0010);
      check("t1_ready", 32'(req_ready), 32'b0010);
      tick();
      drive(1, 8'h42, 1'b0);
      tick();
      drive(1, 8'h43, 1'b1);
      @(negedge clk);
      check("t1_busy", 32'(busy), 32'd1);
      tick();
      release_req(1);
      @(negedge clk);
      check("t1_idle", 32'(busy), 32'd0);
      check("t1_grant_off", 32'(grant), 32'd0);
      check("t1_rr", 32'(dbg_rr_ptr), 32'd2);
      check("t1_writes", 32'(wr_cyc.size()), 32'd3);
      if (wr_cyc.size() == 3) check("t1_consecutive", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
      tick();

      // 2: requesters 0 and 2, two 2-byte messages each; rr_ptr=2 so 2 goes first
      wr_cyc.delete();
      exp_q.push_back(8'h20); exp_q.push_back(8'h21);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      exp_q.push_back(8'h22); exp_q.push_back(8'h23);
      exp_q.push_back(8'h02); exp_q.push_back(8'h03);
      fork
         begin send_msg(0, 8'h00, 8'h01); send_msg(0, 8'h02, 8'h03); end
         begin send_msg(2, 8'h20, 8'h21); send_msg(2, 8'h22, 8'h23); end
      join
      check("t2_writes", 32'(wr_cyc.size()), 32'd8);
      if (wr_cyc.size() == 8) check("t2_span", 32'(wr_cyc[7] - wr_cyc[0]), 32'd10);
      check("t2_rr", 32'(dbg_rr_ptr), 32'd1);
      tick();

      // 3: space gate, free 3 < 4 blocks start; free 4 allows it
      fifo_level = 5'd13;
      exp_q.push_back(8'h33);
      drive(3, 8'h33, 1'b1);
      repeat (5) begin
         tick();
         @(negedge clk);
         check("t3_blocked", 32'(grant), 32'd0);
      end
      tick();
      fifo_level = 5'd12;
      @(negedge clk);
      check("t3_still_idle", 32'(grant), 32'd0);
      tick();
      @(negedge clk);
      check("t3_grant", 32'(grant), 32'b1000);
      tick();
      release_req(3);
      fifo_level = 5'd0;
      tick();

      // 4: fifo_full back-pressure mid-message on requester 0
      wr_cyc.delete();
      exp_q.push_back(8'h50); exp_q.push_back(8'h51);
      exp_q.push_back(8'h52); exp_q.push_back(8'h53);
      drive(0, 8'h50, 1'b0);
      tick();
      @(negedge clk);
      check("t4_grant", 32'(grant), 32'b0001);
      tick();
      drive(0, 8'h51, 1'b0);
      tick();
      fifo_full = 1'b1;
      drive(0, 8'h52, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req_ready != 0 || fifo_wr_en) check("t4_full_blocked", {req_ready, 27'd0, fifo_wr_en}, 32'd0);
         tick();
      end
      check("t4_writes_held", 32'(wr_cyc.size()), 32'd2);
      fifo_full = 1'b0;
      tick();
      drive(0, 8'h53, 1'b1);
      tick();
      release_req(0);
      @(negedge clk);
      check("t4_writes", 32'(wr_cyc.size()), 32'd4);
      check("t4_no_stall", 32'(stall_cnt), 32'd0);
      tick();

      // 5: requester 1 granted then silent; watchdog releases, requester 2 served
      exp_q.push_back(8'h77);
      drive(1, 8'h10, 1'b0);
      drive(2, 8'h77, 1'b1);
      tick();
      release_req(1);
      stall_seen = 0;
      own_cycles = 0;
      for (int i = 0; i < 200 && stall_seen == 0; i++) begin
         @(negedge clk);
         if (stall_err) begin
            stall_seen = 1;
            check("t5_grant_on_stall", 32'(grant), 32'd0);
         end else begin
            if (grant == 4'b0010) own_cycles++;
            tick();
         end
      end
      check("t5_stall_seen", 32'(stall_seen), 32'd1);
      check("t5_owner_cycles", 32'(own_cycles), 32'd64);
      tick();
      @(negedge clk);
      check("t5_next_grant", 32'(grant), 32'b0100);
      check("t5_stall_pulse", 32'(stall_err), 32'd0);
      tick();
      release_req(2);
      check("t5_stall_count", 32'(stall_cnt), 32'd1);
      tick();

      // 6: clear mid-message on requester 3
      exp_q.push_back(8'h60);
      drive(3, 8'h60, 1'b0);
      tick();
      tick();
      drive(3, 8'h61, 1'b0);
      clear = 1'b1;
      @(negedge clk);
      check("t6_fifo_clear", 32'(fifo_clear), 32'd1);
      check("t6_no_write", 32'(fifo_wr_en), 32'd0);
      check("t6_no_ready", 32'(req_ready), 32'd0);
      tick();
      clear = 1'b0;
      @(negedge clk);
      check("t6_grant_off", 32'(grant), 32'd0);
      check("t6_clear_off", 32'(fifo_clear), 32'd0);
      check("t6_rr_kept", 32'(dbg_rr_ptr), 32'd3);
      exp_q.push_back(8'h61); exp_q.push_back(8'h62);
      tick();
      @(negedge clk);
      check("t6_regrant", 32'(grant), 32'b1000);
      tick();
      drive(3, 8'h62, 1'b1);
      tick();
      release_req(3);
      repeat (2) tick();

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
